// File: rtl/serial_rx_pkg.sv
// Shared widths, reference patterns and byte type for the serial byte collector.
package serial_rx_pkg;
    localparam int          BYTE_W = 8;
    localparam logic [7:0]  PAT_A  = 8'hCC;
    localparam logic [7:0]  PAT_B  = 8'hAA;

    typedef logic [BYTE_W-1:0] byte_t;
endpackage

// File: rtl/serial_byte_collector_fifo.sv
// byte_fifo: power-of-two byte FIFO; a push when full is accepted only alongside a pop.
module byte_fifo
    import serial_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  byte_t                  wdata,
    output byte_t                  rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

    byte_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           empty;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/serial_byte_collector.sv
// Collects LSB-first serial bits into bytes and queues them in byte_fifo.
// Optional checker enabled by SERIAL_BYTE_COLLECTOR_PATTERN_CHECK_EN.
module serial_byte_collector
    import serial_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   in_en,
    input  logic                   in_bit,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   err
);
    localparam logic [$clog2(DEPTH):0] FULL_CNT = ($clog2(DEPTH)+1)'(DEPTH);

    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic       byte_done;
    logic       pop;
    byte_t      new_byte;
    byte_t      head;

    assign byte_done = in_en && (bit_cnt == 3'd7);
    assign new_byte  = {in_bit, shreg};
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = head;

    always_ff @(posedge clock) begin
        if (clear) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            overflow <= 1'b0;
        end else begin
            if (in_en) begin
                for (int unsigned i = 0; i < 7; i++)
                    if (bit_cnt == 3'(i))
                        shreg[i] <= in_bit;
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (byte_done && (count == FULL_CNT) && !pop)
                overflow <= 1'b1;
        end
    end

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .clear (clear),
        .push  (byte_done),
        .pop   (pop),
        .wdata (new_byte),
        .rdata (head),
        .count (count)
    );

`ifdef SERIAL_BYTE_COLLECTOR_PATTERN_CHECK_EN
    // Expected pattern alternates on every completed byte, dropped or not.
    logic expect_b;

    always_ff @(posedge clock) begin
        if (clear) begin
            expect_b <= 1'b0;
            err      <= 1'b0;
        end else if (byte_done) begin
            expect_b <= ~expect_b;
            if (new_byte != (expect_b ? PAT_B : PAT_A))
                err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule
